// File: rtl/candy_sprite_fetch.sv
// Sprite pixel fetcher: walks a packed 4bpp sprite in ROM and streams visible
// (palette index, framebuffer address) pairs over a valid/ready handshake.
module candy_sprite_fetch #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int ROM_AW   = 16,
    parameter int FB_AW    = 17
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ROM_AW-1:0] base_addr,
    input  logic [9:0]        pos_x,
    input  logic [8:0]        pos_y,
    input  logic [7:0]        spr_w,
    input  logic [7:0]        spr_h,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [3:0]        pix_index,
    output logic [FB_AW-1:0]  pix_addr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [9:0]        pos_x_r;
    logic [8:0]        pos_y_r;
    logic [7:0]        spr_w_r, spr_h_r;
    logic [7:0]        col_r, col_s, row_r, row_s;
    logic [15:0]       shift_r, shift_s;
    logic [2:0]        nib_r, nib_s;
    logic              busy_r, busy_s, done_r, done_s;
    logic              pix_valid_r, pix_valid_s;
    logic [3:0]        pix_index_r, pix_index_s;
    logic [FB_AW-1:0]  pix_addr_r, pix_addr_s;
    logic [ROM_AW-1:0] rom_addr_r, rom_addr_s;
    logic              retire_s, last_nib_s, last_pix_s, empty_s;
    logic [10:0]       x_s, y_s;

    function automatic logic pix_visible(input logic [3:0] idx, input logic [10:0] x,
                                         input logic [10:0] y);
        return (idx != 4'd0) && (x < 11'(SCREEN_W)) && (y < 11'(SCREEN_H));
    endfunction

    // A hidden pixel is never presented, so it retires without waiting for ready.
    assign retire_s   = (state_r == S_EMIT) && (!pix_valid_r || pix_ready);
    assign last_nib_s = (nib_r == 3'd1);
    assign last_pix_s = ((col_r + 8'd1) == spr_w_r) && ((row_r + 8'd1) == spr_h_r);
    assign empty_s    = (spr_w == 8'd0) || (spr_h == 8'd0);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = empty_s ? S_DONE : S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: state_s = S_WAIT;
            S_WAIT:  state_s = S_EMIT;
            S_EMIT: begin
                if (retire_s && last_nib_s) begin
                    state_s = last_pix_s ? S_DONE : S_FETCH;
                end else begin
                    state_s = S_EMIT;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Pixel walk: nibble shift register and row/column counters.
    always_comb begin
        col_s   = col_r;
        row_s   = row_r;
        shift_s = shift_r;
        nib_s   = nib_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    col_s = 8'd0;
                    row_s = 8'd0;
                end else begin
                    col_s = col_r;
                    row_s = row_r;
                end
            end
            S_WAIT: begin
                shift_s = rom_data;
                nib_s   = 3'd4;
            end
            S_EMIT: begin
                if (retire_s) begin
                    shift_s = {shift_r[11:0], 4'h0};
                    nib_s   = nib_r - 3'd1;
                    if ((col_r + 8'd1) == spr_w_r) begin
                        col_s = 8'd0;
                        row_s = row_r + 8'd1;
                    end else begin
                        col_s = col_r + 8'd1;
                        row_s = row_r;
                    end
                end else begin
                    shift_s = shift_r;
                    nib_s   = nib_r;
                end
            end
            default: begin
                shift_s = shift_r;
                nib_s   = nib_r;
            end
        endcase
    end

    // Output logic: next-cycle values of the registered outputs, derived from the next pixel.
    always_comb begin
        x_s         = {1'b0, pos_x_r} + {3'b000, col_s};
        y_s         = {2'b00, pos_y_r} + {3'b000, row_s};
        pix_valid_s = (state_s == S_EMIT) && pix_visible(shift_s[15:12], x_s, y_s);
        if (pix_valid_s) begin
            pix_index_s = shift_s[15:12];
            pix_addr_s  = FB_AW'(y_s) * FB_AW'(SCREEN_W) + FB_AW'(x_s);
        end else begin
            pix_index_s = pix_index_r;
            pix_addr_s  = pix_addr_r;
        end
        busy_s = (state_s == S_FETCH) || (state_s == S_WAIT) || (state_s == S_EMIT);
        done_s = (state_s == S_DONE);
        if (state_s == S_FETCH) begin
            if (state_r == S_IDLE) begin
                rom_addr_s = base_addr;
            end else begin
                rom_addr_s = rom_addr_r + ROM_AW'(1'b1);
            end
        end else begin
            rom_addr_s = rom_addr_r;
        end
    end

    // Datapath and output registers; sprite geometry is latched on an accepted start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pos_x_r     <= 10'd0;
            pos_y_r     <= 9'd0;
            spr_w_r     <= 8'd0;
            spr_h_r     <= 8'd0;
            col_r       <= 8'd0;
            row_r       <= 8'd0;
            shift_r     <= 16'd0;
            nib_r       <= 3'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pix_valid_r <= 1'b0;
            pix_index_r <= 4'd0;
            pix_addr_r  <= '0;
            rom_addr_r  <= '0;
        end else begin
            if ((state_r == S_IDLE) && start) begin
                pos_x_r <= pos_x;
                pos_y_r <= pos_y;
                spr_w_r <= spr_w;
                spr_h_r <= spr_h;
            end
            col_r       <= col_s;
            row_r       <= row_s;
            shift_r     <= shift_s;
            nib_r       <= nib_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pix_valid_r <= pix_valid_s;
            pix_index_r <= pix_index_s;
            pix_addr_r  <= pix_addr_s;
            rom_addr_r  <= rom_addr_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pix_valid = pix_valid_r;
    assign pix_index = pix_index_r;
    assign pix_addr  = pix_addr_r;
    assign rom_addr  = rom_addr_r;

endmodule
